// File: rtl/div_sequencer.sv
// Signed restoring-divide sequencer: result strobe 33 edges after the start edge (1 edge for divide-by-zero).
// No backpressure: a start is accepted in any state and restarts the operation in flight.
module div_sequencer #(
   parameter int WIDTH      = 32,
   parameter int COUNT_BITS = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

   state_t                  state_q;
   logic [COUNT_BITS-1:0]   cnt_q;
   logic [2*WIDTH-1:0]      acc_q;
   logic [2*WIDTH-1:0]      acc_d;
   logic [2*WIDTH-1:0]      shifted;
   logic [WIDTH:0]          diff;
   logic [WIDTH-1:0]        bmag_q;
   logic [WIDTH-1:0]        a_mag;
   logic [WIDTH-1:0]        b_mag;
   logic                    qneg_q;
   logic                    rneg_q;
   logic                    ovf_q;
   logic                    ovf_d;

   // Magnitude of the most negative value wraps to itself, read back as unsigned.
   assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign ovf_d = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);

   assign shifted = acc_q << 1;
   assign diff    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, bmag_q};
   assign acc_d   = diff[WIDTH] ? shifted
                                : {diff[WIDTH-1:0], shifted[WIDTH-1:0] | WIDTH'(1)};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         acc_q          <= '0;
         bmag_q         <= '0;
         qneg_q         <= 1'b0;
         rneg_q         <= 1'b0;
         ovf_q          <= 1'b0;
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_DIV) begin
            acc_q   <= {{WIDTH{1'b0}}, a_mag};
            bmag_q  <= b_mag;
            qneg_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            rneg_q  <= data_operandA[WIDTH-1];
            ovf_q   <= ovf_d;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= (data_operandB == '0) ? ERR : RUN;
         end else begin
            case (state_q)
               RUN: begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + COUNT_BITS'(1);
                  if (cnt_q == COUNT_BITS'(WIDTH-1)) state_q <= DONE;
               end
               DONE: begin
                  data_result    <= qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                  data_remainder <= rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                  data_exception <= ovf_q;
                  data_resultRDY <= 1'b1;
                  busy           <= 1'b0;
                  state_q        <= IDLE;
               end
               ERR: begin
                  data_result    <= '0;
                  data_remainder <= '0;
                  data_exception <= 1'b1;
                  data_resultRDY <= 1'b1;
                  busy           <= 1'b0;
                  state_q        <= IDLE;
               end
               IDLE: ;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Iteration controller for the signed 32-bit restoring divider in the multdiv unit.
- Accepts a start pulse and operands, then runs 32 shift/trial-subtract iterations on a 64-bit {remainder, quotient} register.
- Raises a one-cycle ready strobe carrying the signed quotient, the signed remainder and an exception flag.
- Sits beside the quotient-control datapath: it owns the iteration counter, sign fix-up and handshake, and feeds the pipeline's multdiv writeback.

Parameters:
- WIDTH, 32: operand and result width. The internal register is 2*WIDTH.
- COUNT_BITS, 6: iteration counter width. Must hold the value WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- ctrl_DIV  input  1  start pulse. Operands are sampled on the edge where it is high.
- data_operandA  input  WIDTH  dividend, two's complement
- data_operandB  input  WIDTH  divisor, two's complement
- data_result  output  WIDTH  signed quotient
- data_remainder  output  WIDTH  signed remainder
- data_exception  output  1  divide-by-zero or overflow; valid while data_resultRDY is high
- data_resultRDY  output  1  one-cycle result-valid strobe
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE; counter=0; 64-bit register=0.
  - data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0.
- Reset mid-operation aborts the operation. No ready strobe is produced for the aborted divide.
- States: IDLE, RUN, DONE, ERR.
- Start (ctrl_DIV high at edge t0), accepted in any state, restarts any operation in flight:
  - |A| and |B| are computed, and the magnitudes are latched.
  - qneg=A[31]^B[31]; rneg=A[31].
  - Register loads {32'b0, |A|}; counter=0; busy=1.
  - If B==0, next state is ERR. Otherwise next state is RUN.
- RUN, one iteration per edge (t1..t32):
  - shifted = reg<<1.
  - diff = shifted[63:32] - |B|, computed 33 bits wide.
  - If diff is non-negative: upper half = diff[31:0] and bit0 = 1. Otherwise upper half = shifted[63:32] and bit0 = 0.
  - counter increments. At the edge where counter reaches WIDTH (t32), next state is DONE.
- DONE, edge t33:
  - data_result = qneg ? -Q : Q, where Q is the low half.
  - data_remainder = rneg ? -R : R, where R is the high half.
  - data_resultRDY=1 for exactly one cycle; busy=0; next state is IDLE.
  - Ready is therefore 33 edges after the start edge.
- Overflow: if A==0x80000000 and B==0xFFFFFFFF, then data_result=0x80000000 (the wrapped value), data_remainder=0, data_exception=1. All other DONE results give data_exception=0.
- ERR, edge t1:
  - data_result=0, data_remainder=0, data_exception=1, data_resultRDY=1 for one cycle; busy=0; next state is IDLE.
- data_result, data_remainder and data_exception hold their values after the strobe until the next strobe or reset.
- If ctrl_DIV is high on the DONE or ERR edge, the start wins. No strobe is produced for the old operation, and the new operation loads as at t0.
- |0x80000000| is handled as unsigned 0x80000000. The 33-bit diff covers the full magnitude range.
- ctrl_DIV held high across multiple edges restarts on every edge. Ready occurs 33 edges after the last high sample.

Test Plan:
- A=100, B=7, pulse ctrl_DIV -> at edge t33: resultRDY=1 for 1 cycle, result=14, remainder=2, exception=0. busy is high from t0 to t33.
- A=-100 (0xFFFFFF9C), B=7 -> result=-14 (0xFFFFFFF2), remainder=-2. A=100, B=-7 -> result=-14, remainder=2. A=-100, B=-7 -> result=14, remainder=-2.
- A=5, B=0 -> at edge t1: resultRDY=1, exception=1, result=0. No further strobe follows.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1. A=0x80000000, B=1 -> result=0x80000000, exception=0.
- Start A=100, B=7, then at edge t10 restart with A=9, B=3 -> a single strobe at t10+33 with result=3, remainder=0. Drive reset_n low at t5 of a new divide -> all outputs are 0 immediately and no strobe follows.
- Random sweep of 1000 operand pairs (B≠0) against a reference model. Check quotient, remainder sign and the 33-edge latency for each.
